// File: rtl/fphub_special_resolver.sv
// Special-operand resolver for HUB divide/multiply: classifies X and Y, resolves
// zero/inf/one cases in a STAGES-deep elastic pipeline, and tracks sticky exception state.
module fphub_special_resolver #(
  parameter int M      = 23,
  parameter int E      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [E+M:0]     X,
  input  logic [E+M:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_special,
  output logic [E+M:0]     special_result,
  output logic             out_dz,
  output logic             out_inv,
  output logic             flag_dz,
  output logic             flag_inv,
  input  logic             flag_clr,
  output logic [CNT_W-1:0] special_cnt
);

  localparam int W = E + M + 1;
  localparam logic [E-1:0]     ONE_EXP = {1'b0, {(E-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_ONE} cls_e;

  typedef struct packed {
    logic         vld;
    logic         spec;
    logic         dz;
    logic         inv;
    logic [W-1:0] res;
  } stage_t;

  function automatic cls_e classify(input logic [W-1:0] v);
    cls_e c;
    if (v[W-2:0] == '0)                             c = CLS_ZERO;
    else if (&v[W-2:0])                             c = CLS_INF;
    else if (v[W-2:M] == ONE_EXP && v[M-1:0] == '0) c = CLS_ONE;
    else                                            c = CLS_NORMAL;
    return c;
  endfunction

  cls_e         clsX;
  cls_e         clsY;
  logic         sgn;
  logic [W-1:0] infS;
  logic [W-1:0] zeroS;
  logic [W-1:0] invalidVal;
  stage_t       stage_d;
  stage_t       pipe_q [STAGES];
  logic         advance;
  logic         deliver;

  assign clsX       = classify(X);
  assign clsY       = classify(Y);
  assign sgn        = X[W-1] ^ Y[W-1];
  assign infS       = {sgn, {(W-1){1'b1}}};
  assign zeroS      = {sgn, {(W-1){1'b0}}};
  assign invalidVal = {W{1'b1}};

  // Bubbles carry all-zero payload so a non-special or empty slot shows a zero result.
  always_comb begin
    stage_d     = '0;
    stage_d.vld = in_valid;
    if (in_valid) begin
      if (!op) begin
        if ((clsX == CLS_INF && clsY == CLS_INF) || (clsX == CLS_ZERO && clsY == CLS_ZERO)) begin
          stage_d.spec = 1'b1; stage_d.inv = 1'b1; stage_d.res = invalidVal;
        end else if (clsY == CLS_ZERO) begin
          stage_d.spec = 1'b1; stage_d.dz = 1'b1; stage_d.res = infS;
        end else if (clsX == CLS_INF) begin
          stage_d.spec = 1'b1; stage_d.res = infS;
        end else if (clsY == CLS_INF || clsX == CLS_ZERO) begin
          stage_d.spec = 1'b1; stage_d.res = zeroS;
        end else if (clsY == CLS_ONE) begin
          stage_d.spec = 1'b1; stage_d.res = {sgn, X[W-2:0]};
        end
      end else begin
        if ((clsX == CLS_INF && clsY == CLS_ZERO) || (clsX == CLS_ZERO && clsY == CLS_INF)) begin
          stage_d.spec = 1'b1; stage_d.inv = 1'b1; stage_d.res = invalidVal;
        end else if (clsX == CLS_INF || clsY == CLS_INF) begin
          stage_d.spec = 1'b1; stage_d.res = infS;
        end else if (clsX == CLS_ZERO || clsY == CLS_ZERO) begin
          stage_d.spec = 1'b1; stage_d.res = zeroS;
        end else if (clsY == CLS_ONE) begin
          stage_d.spec = 1'b1; stage_d.res = {sgn, X[W-2:0]};
        end else if (clsX == CLS_ONE) begin
          stage_d.spec = 1'b1; stage_d.res = {sgn, Y[W-2:0]};
        end
      end
    end
  end

  assign advance  = out_ready | ~pipe_q[STAGES-1].vld;
  assign in_ready = advance;

  // All stages move in lockstep; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
    end else if (advance) begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_valid      = pipe_q[STAGES-1].vld;
  assign is_special     = pipe_q[STAGES-1].spec;
  assign special_result = pipe_q[STAGES-1].res;
  assign out_dz         = pipe_q[STAGES-1].dz;
  assign out_inv        = pipe_q[STAGES-1].inv;
  assign deliver        = out_valid & out_ready;

  logic             flagDz_q, flagDz_d;
  logic             flagInv_q, flagInv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A delivery coinciding with a clear survives the clear.
  always_comb begin
    flagDz_d  = flagDz_q | (deliver & out_dz);
    flagInv_d = flagInv_q | (deliver & out_inv);
    cnt_d     = cnt_q;
    if (deliver && is_special && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    if (flag_clr) begin
      flagDz_d  = deliver & out_dz;
      flagInv_d = deliver & out_inv;
      cnt_d     = '0;
      cnt_d[0]  = deliver & is_special;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagDz_q  <= 1'b0;
      flagInv_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      flagDz_q  <= flagDz_d;
      flagInv_q <= flagInv_d;
      cnt_q     <= cnt_d;
    end
  end

  assign flag_dz     = flagDz_q;
  assign flag_inv    = flagInv_q;
  assign special_cnt = cnt_q;

endmodule

// File: tb/tb_fphub_special_resolver.sv
// Scoreboard bench for fphub_special_resolver: directed vectors queue expected
// results, a negedge monitor pops and checks them along with sticky flags and counters.
module tb_fphub_special_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, op, out_ready, flag_clr;
  logic [31:0] X, Y;
  logic        in_ready, out_valid, is_special, out_dz, out_inv, flag_dz, flag_inv;
  logic [31:0] special_result;
  logic [15:0] special_cnt;
  logic        in_readyB, out_validB, is_specialB, out_dzB, out_invB, flag_dzB, flag_invB;
  logic [31:0] special_resultB;
  logic [1:0]  special_cntB;

  typedef struct {
    logic        spec;
    logic [31:0] res;
    logic        dz;
    logic        inv;
  } exp_t;

  exp_t        sb[$];
  int          assertCount = 0;
  int          failCount = 0;
  logic        expDz = 1'b0, expInv = 1'b0;
  int          expCnt = 0, expCntB = 0;
  logic        prevStall = 1'b0;
  logic [31:0] prevRes;
  logic        prevSpec, prevDz, prevInv;

  always #5 clk = ~clk;

  fphub_special_resolver #(.M(23), .E(8), .STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready), .is_special(is_special),
    .special_result(special_result), .out_dz(out_dz), .out_inv(out_inv),
    .flag_dz(flag_dz), .flag_inv(flag_inv), .flag_clr(flag_clr), .special_cnt(special_cnt)
  );

  // Narrow-counter copy sharing all inputs, used for saturation checks.
  fphub_special_resolver #(.M(23), .E(8), .STAGES(2), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_readyB), .op(op),
    .X(X), .Y(Y), .out_valid(out_validB), .out_ready(out_ready), .is_special(is_specialB),
    .special_result(special_resultB), .out_dz(out_dzB), .out_inv(out_invB),
    .flag_dz(flag_dzB), .flag_inv(flag_invB), .flag_clr(flag_clr), .special_cnt(special_cntB)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares against the scoreboard head and the flag/counter model, then
  // advances the model by what the coming clock edge is supposed to do.
  always @(negedge clk) begin
    exp_t it;
    logic d;
    if (!rst_n) begin
      sb.delete();
      expDz = 1'b0; expInv = 1'b0; expCnt = 0; expCntB = 0; prevStall = 1'b0;
    end else begin
      checkOutput("flag_dz", flag_dz, expDz);
      checkOutput("flag_inv", flag_inv, expInv);
      checkOutput("special_cnt", special_cnt, expCnt);
      checkOutput("special_cnt_w2", special_cntB, expCntB);
      if (prevStall) begin
        checkOutput("hold_result", special_result, prevRes);
        checkOutput("hold_special", is_special, prevSpec);
        checkOutput("hold_dz", out_dz, prevDz);
        checkOutput("hold_inv", out_inv, prevInv);
      end
      d = 1'b0;
      it = '{spec: 1'b0, res: 32'h0, dz: 1'b0, inv: 1'b0};
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", out_valid, 1'b0);
        end else begin
          it = sb[0];
          checkOutput("is_special", is_special, it.spec);
          checkOutput("special_result", special_result, it.res);
          checkOutput("out_dz", out_dz, it.dz);
          checkOutput("out_inv", out_inv, it.inv);
          if (out_ready) begin
            void'(sb.pop_front());
            d = 1'b1;
          end
        end
      end
      if (flag_clr) begin
        expDz   = d & it.dz;
        expInv  = d & it.inv;
        expCnt  = (d && it.spec) ? 1 : 0;
        expCntB = expCnt;
      end else if (d) begin
        expDz  = expDz | it.dz;
        expInv = expInv | it.inv;
        if (it.spec) begin
          if (expCnt < 65535) expCnt++;
          if (expCntB < 3) expCntB++;
        end
      end
      prevStall = out_valid & ~out_ready;
      prevRes = special_result; prevSpec = is_special; prevDz = out_dz; prevInv = out_inv;
    end
  end

  // Presents one operand pair and waits for the edge that accepts it.
  task automatic applyStimulus(input logic opIn, input logic [31:0] xIn, input logic [31:0] yIn,
                               input logic eSpec, input logic [31:0] eRes,
                               input logic eDz, input logic eInv);
    bit accepted = 0;
    op = opIn; X = xIn; Y = yIn; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{spec: eSpec, res: eRes, dz: eDz, inv: eInv});
        accepted = 1;
        break;
      end
    end
    if (!accepted) checkOutput("accept_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 50; t++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    checkOutput("drain_pending", sb.size(), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; X = '0; Y = '0; out_ready = 1'b0; flag_clr = 1'b0;
    cycles(3);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_result", special_result, 32'h0);
    checkOutput("reset_cnt", special_cnt, 16'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(1);

    // Divide by one and minus one, including the two-cycle latency.
    applyStimulus(1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40400000, 1'b0, 1'b0);
    checkOutput("latency_early", out_valid, 1'b0);
    cycles(1);
    checkOutput("latency_valid", out_valid, 1'b1);
    checkOutput("latency_result", special_result, 32'h40400000);
    applyStimulus(1'b0, 32'h40400000, 32'hBF800000, 1'b1, 32'hC0400000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h40400000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    waitDrain();
    cycles(1);
    checkOutput("dz_sticky", flag_dz, 1'b1);

    applyStimulus(1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h40400000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h80000000, 32'h40400000, 1'b1, 32'h80000000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3F800000, 32'hC0400000, 1'b1, 32'hC0400000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h00000000, 32'h80000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h7FFFFFFF, 32'hC0000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h40400000, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h80000000, 32'h40400000, 1'b1, 32'h80000000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h40400000, 32'h40000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    waitDrain();
    cycles(1);
    checkOutput("dz_still_set", flag_dz, 1'b1);
    checkOutput("inv_set", flag_inv, 1'b1);
    flag_clr = 1'b1;
    cycles(1);
    flag_clr = 1'b0;
    checkOutput("clr_dz", flag_dz, 1'b0);
    checkOutput("clr_cnt", special_cnt, 16'h0);

    // Back-to-back pair held behind a three-cycle output stall.
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40400000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h40400000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_in_ready", in_ready, 1'b0);
      checkOutput("stall_out_valid", out_valid, 1'b1);
      checkOutput("stall_result", special_result, 32'h40400000);
      cycles(1);
    end
    out_ready = 1'b1;
    waitDrain();
    cycles(1);
    checkOutput("stall_cnt", special_cnt, 16'd2);

    // Clear lands in the same cycle an invalid result is delivered.
    applyStimulus(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    cycles(1);
    flag_clr = 1'b1;
    cycles(1);
    flag_clr = 1'b0;
    checkOutput("clr_deliv_inv", flag_inv, 1'b1);
    checkOutput("clr_deliv_dz", flag_dz, 1'b0);
    checkOutput("clr_deliv_cnt", special_cnt, 16'd1);

    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h00000000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    waitDrain();
    cycles(1);
    checkOutput("sat_cnt_w2", special_cntB, 2'd3);
    checkOutput("cnt_w16", special_cnt, 16'd6);

    // Reset with two results in flight.
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40400000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h40400000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_flag_inv", flag_inv, 1'b0);
    checkOutput("rst_cnt", special_cnt, 16'h0);
    checkOutput("rst_result", special_result, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(10);
    checkOutput("post_rst_cnt", special_cnt, 16'h0);
    checkOutput("post_rst_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
